// File: rtl/shuffle_pkg.sv
// Shared types and helpers for the shuffle scheduler: FSM states, shuffle steps,
// and the step-count saturation applied to incoming requests.
package shuffle_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  typedef enum logic [2:0] {S0, S1, S2, S3, S4} step_e;

  localparam int MAX_STEPS = 5;

  // Step counts above the length of the shuffle sequence run the full sequence.
  function automatic logic [2:0] sat_steps(input logic [2:0] k);
    return (k > 3'(MAX_STEPS)) ? 3'(MAX_STEPS) : k;
  endfunction

endpackage

// File: rtl/shuffle_sched_if.sv
// Request/response channel between requester front-ends and the shuffle scheduler.
interface shuffle_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0][7:0] req_a;
  logic [NUM_REQ-1:0][7:0] req_b;
  logic [NUM_REQ-1:0][2:0] req_steps;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [15:0]             rsp_data;
  logic [ID_W-1:0]         rsp_id;

  modport master (
    output req_valid, req_a, req_b, req_steps, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_steps, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shuffle_core.sv
// 16-bit shuffle datapath register D: loads {B, A}, then applies one selected step per enable.
module shuffle_core
  import shuffle_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step_en,
  input  step_e       step_sel,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] d
);

  logic [15:0] d_q, d_d;

  always_comb begin
    d_d = d_q;
    if (load) begin
      d_d = {b, a};
    end else if (step_en) begin
      case (step_sel)
        S0:      d_d = {a, d_q[7:0]};
        S1:      d_d = {d_q[15:8], b};
        S2:      d_d = {d_q[7:0], d_q[15:8]};
        S3:      d_d = {d_q[3:0], d_q[7:4], d_q[11:8], d_q[15:12]};
        S4:      d_d = {15'b0, ^d_q};
        default: d_d = d_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_q <= '0;
    end else begin
      d_q <= d_d;
    end
  end

  assign d = d_q;

endmodule

// File: rtl/shuffle_sched.sv
// Round-robin scheduler sharing one shuffle_core among NUM_REQ requesters; one
// operation in flight, result held on a valid/ready response channel.
module shuffle_sched
  import shuffle_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic         clk,
  input  logic         reset_n,
  shuffle_sched_if.slave bus,
  output logic         busy,
  output logic [7:0]   done_count
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     last_id_q, id_q;
  logic [7:0]          a_q, b_q;
  logic [2:0]          k_q;
  logic                busy_q;
  logic [7:0]          done_q;

  logic [NUM_REQ-1:0]  grant_vec;
  logic [ID_W-1:0]     grant_id;
  logic [ID_W-1:0]     cand;
  logic                found;
  logic                accept;
  logic                rsp_hs;
  logic                load;
  logic                step_en;
  logic [15:0]         d;

  // Search starts one past the last granted requester.
  always_comb begin
    grant_vec = '0;
    grant_id  = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(last_id_q) + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found           = 1'b1;
        grant_id        = cand;
        grant_vec[cand] = 1'b1;
      end
    end
  end

  assign bus.req_ready = (reset_n && state_q == IDLE) ? grant_vec : '0;
  assign accept        = (state_q == IDLE) && found;
  assign rsp_hs        = (state_q == DONE) && bus.rsp_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        cnt_d   = '0;
        state_d = (k_q == 3'd0) ? DONE : RUN;
      end
      RUN: begin
        step_en = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == k_q - 3'd1) state_d = DONE;
      end
      DONE: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      last_id_q <= ID_W'(NUM_REQ - 1);
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        last_id_q <= grant_id;
        id_q      <= grant_id;
        a_q       <= bus.req_a[grant_id];
        b_q       <= bus.req_b[grant_id];
        k_q       <= sat_steps(bus.req_steps[grant_id]);
        busy_q    <= 1'b1;
      end else if (rsp_hs) begin
        busy_q <= 1'b0;
        done_q <= done_q + 8'd1;
      end
    end
  end

  shuffle_core u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .step_en  (step_en),
    .step_sel (step_e'(cnt_q)),
    .a        (a_q),
    .b        (b_q),
    .d        (d)
  );

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = d;
  assign bus.rsp_id    = id_q;
  assign busy          = busy_q;
  assign done_count    = done_q;

endmodule
